mcpu_reset_seq: RTL and testbench
=================================

# mcpu_reset_seq

Parametrised reset sequencer and run monitor for MCPU core simulation and FPGA bring-up. Takes the board-level asynchronous active-low reset and synchronises its release. Holds the core in reset for a programmable interval, then releases up to NUM_CHANNELS downstream reset domains one at a time, in a staggered order. After full release it counts core cycles and can freeze the core at a fixed run limit. This replaces hand-written clock/reset stimulus in top-level harnesses and is synthesisable for hardware.

## Interface
Parameters:
- SYNC_STAGES, 2: reset-release synchroniser depth (≥2).
- HOLD_CYCLES, 4: cycles reset stays asserted after synchronised release (≥1).
- NUM_CHANNELS, 2: number of downstream reset outputs (1–16).
- STAGGER, 2: cycles between successive channel releases (≥1).
- CYC_WIDTH, 32: cycle counter width.
- RUN_LIMIT, 0: cycles to run before freeze; 0 = unlimited.

Ports:
- clkrst_core_clk  in  1  core clock; single domain.
- clkrst_core_rst_n  in  1  asynchronous, active-low reset.
- sw_rst_req  in  1  synchronous soft-reset request, sampled every edge.
- rst_out_n  out  NUM_CHANNELS  per-domain active-low resets; bit 0 released first.
- all_released  out  1  high when every rst_out_n bit is 1.
- cycle_count  out  CYC_WIDTH  cycles since full release.
- run_limit_hit  out  1  sticky; core frozen by RUN_LIMIT.

## Operation
- States: SYNC, HOLD, RELEASE, RUN, LIMIT.
- Async reset behaviour:
  - clkrst_core_rst_n=0 immediately clears the synchroniser and forces state SYNC.
  - Reset values: rst_out_n all 0, all_released 0, cycle_count 0, run_limit_hit 0.
- SYNC: wait until the synchroniser output is 1, then go to HOLD and clear the hold counter.
- HOLD: count HOLD_CYCLES edges, then go to RELEASE.
  - rst_out_n[0] deasserts on the HOLD_CYCLES-th edge counted in HOLD.
- RELEASE: rst_out_n[k] deasserts STAGGER edges after rst_out_n[k-1].
  - The edge that releases the last channel sets all_released=1, loads cycle_count=0 and enters RUN.
- RUN:
  - cycle_count increments by 1 each edge and saturates at all-ones, with no wrap.
  - If RUN_LIMIT≠0 and the increment would make cycle_count equal RUN_LIMIT: on that edge, store RUN_LIMIT, set run_limit_hit, reassert all rst_out_n, clear all_released, and enter LIMIT.
- LIMIT: remain here with cycle_count frozen, until async reset or sw_rst_req.
- sw_rst_req=1 in HOLD, RELEASE, RUN or LIMIT, on the next edge:
  - all rst_out_n go 0, all_released 0, cycle_count 0, run_limit_hit 0.
  - Enter HOLD with the counter cleared.
  - Ignored in SYNC.
- Async reset is reapplied through the full SYNC path, whatever the current state.
- rst_out_n bits are driven directly from flops (no glitches), assert asynchronously on input reset, and deassert only synchronously.

## Timing
- Synchroniser: if clkrst_core_rst_n rises before edge n, the synchroniser output is 1 after edge n+SYNC_STAGES-1. Call that edge E0.
- Channel release: rst_out_n[k]=1 after edge E0+HOLD_CYCLES+k·STAGGER.
- Full release: all_released and cycle_count=0 appear after edge Er = E0+HOLD_CYCLES+(NUM_CHANNELS-1)·STAGGER.
- Counting: cycle_count=m after edge Er+m.
- Run limit: run_limit_hit=1 after edge Er+RUN_LIMIT.
- Soft reset: sw_rst_req high at edge S means rst_out_n[0] releases after edge S+HOLD_CYCLES.
- Reset asserted mid-RELEASE or mid-RUN: all outputs return to reset values within the same cycle, combinationally through the async clear.

## Test plan
- Default parameters, reset deasserted before edge 1:
  - E0=2; rst_out_n=01 after edge 6, =11 after edge 8.
  - all_released=1 after edge 8; cycle_count=0 after edge 8, =5 after edge 13.
- RUN_LIMIT=10, defaults otherwise:
  - run_limit_hit=1, rst_out_n=00, cycle_count=10 after edge 18.
  - Values hold unchanged through edge 40.
- NUM_CHANNELS=4, STAGGER=3: releases after edges 6, 9, 12, 15; all_released after edge 15.
- sw_rst_req pulse at edge 20 in RUN:
  - After edge 20: rst_out_n=00, cycle_count=0.
  - rst_out_n=01 after edge 24, =11 after edge 26.
- Async reset pulse between edges 7 and 8 (mid-RELEASE):
  - Outputs clear immediately.
  - On release before edge 10: sequence restarts with E0=11, rst_out_n[0] after edge 15.
- CYC_WIDTH=4, RUN_LIMIT=0: cycle_count saturates at 15, with no wrap, after edge Er+15 and later.

Source files
------------

// File: rtl/mcpu_reset_seq.sv
// Reset sequencer and run monitor: synchronised reset release, hold interval,
// staggered per-domain release, cycle counting and optional run-limit freeze.
module mcpu_reset_seq #(
    parameter int SYNC_STAGES  = 2,
    parameter int HOLD_CYCLES  = 4,
    parameter int NUM_CHANNELS = 2,
    parameter int STAGGER      = 2,
    parameter int CYC_WIDTH    = 32,
    parameter int RUN_LIMIT    = 0
) (
    input  logic                    clkrst_core_clk,
    input  logic                    clkrst_core_rst_n,
    input  logic                    sw_rst_req,
    output logic [NUM_CHANNELS-1:0] rst_out_n,
    output logic                    all_released,
    output logic [CYC_WIDTH-1:0]    cycle_count,
    output logic                    run_limit_hit
);

    localparam int SW = SYNC_STAGES - 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int GW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam logic [CYC_WIDTH-1:0] LIMIT_VAL = CYC_WIDTH'(RUN_LIMIT);

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_HOLD,
        ST_RELEASE,
        ST_RUN,
        ST_LIMIT
    } state_t;

    state_t                  state, state_nxt;
    logic [SW-1:0]           sync_q;
    logic                    sync_done;
    logic [HW-1:0]           hold_cnt, hold_nxt;
    logic [GW-1:0]           stg_cnt, stg_nxt;
    logic [NUM_CHANNELS-1:0] rst_q, rst_nxt, rel_vec;
    logic                    all_q, all_nxt;
    logic [CYC_WIDTH-1:0]    cyc_q, cyc_nxt, cyc_inc;
    logic                    hit_q, hit_nxt;
    logic                    release_step;

    // The state register acts as the final synchroniser stage: SYNC is left on
    // the very edge a SYNC_STAGES-deep chain would present a released reset.
    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= (sync_q << 1) | SW'(1);
        end
    end

    assign sync_done = sync_q[SW-1];

    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            state    <= ST_SYNC;
            hold_cnt <= '0;
            stg_cnt  <= '0;
            rst_q    <= '0;
            all_q    <= 1'b0;
            cyc_q    <= '0;
            hit_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            stg_cnt  <= stg_nxt;
            rst_q    <= rst_nxt;
            all_q    <= all_nxt;
            cyc_q    <= cyc_nxt;
            hit_q    <= hit_nxt;
        end
    end

    // Channels release as a thermometer code, lowest bit first.
    assign rel_vec = (rst_q << 1) | NUM_CHANNELS'(1);
    assign cyc_inc = cyc_q + CYC_WIDTH'(1);

    always_comb begin
        state_nxt    = state;
        hold_nxt     = hold_cnt;
        stg_nxt      = stg_cnt;
        rst_nxt      = rst_q;
        all_nxt      = all_q;
        cyc_nxt      = cyc_q;
        hit_nxt      = hit_q;
        release_step = 1'b0;

        if (state != ST_SYNC && sw_rst_req) begin
            state_nxt = ST_HOLD;
            hold_nxt  = '0;
            stg_nxt   = '0;
            rst_nxt   = '0;
            all_nxt   = 1'b0;
            cyc_nxt   = '0;
            hit_nxt   = 1'b0;
        end else begin
            case (state)
                ST_SYNC: begin
                    if (sync_done) begin
                        state_nxt = ST_HOLD;
                        hold_nxt  = '0;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                        release_step = 1'b1;
                    end else begin
                        hold_nxt = hold_cnt + HW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (stg_cnt == GW'(STAGGER - 1)) begin
                        release_step = 1'b1;
                    end else begin
                        stg_nxt = stg_cnt + GW'(1);
                    end
                end
                ST_RUN: begin
                    if (cyc_q != '1) begin
                        if (RUN_LIMIT != 0 && cyc_inc == LIMIT_VAL) begin
                            state_nxt = ST_LIMIT;
                            cyc_nxt   = LIMIT_VAL;
                            hit_nxt   = 1'b1;
                            rst_nxt   = '0;
                            all_nxt   = 1'b0;
                        end else begin
                            cyc_nxt = cyc_inc;
                        end
                    end
                end
                ST_LIMIT: begin
                end
                default: begin
                    state_nxt = ST_SYNC;
                end
            endcase

            if (release_step) begin
                rst_nxt = rel_vec;
                stg_nxt = '0;
                if (rel_vec == '1) begin
                    state_nxt = ST_RUN;
                    all_nxt   = 1'b1;
                    cyc_nxt   = '0;
                end else begin
                    state_nxt = ST_RELEASE;
                end
            end
        end
    end

    assign rst_out_n     = rst_q;
    assign all_released  = all_q;
    assign cycle_count   = cyc_q;
    assign run_limit_hit = hit_q;

endmodule

// File: tb/tb_mcpu_reset_seq.sv
// Directed bench for mcpu_reset_seq: four instances covering run limit,
// wide staggered release with counter saturation, soft reset and async re-reset.
module tb_mcpu_reset_seq;

    logic clk;
    logic rst_a_n;
    logic rst_d_n;
    logic sw_c;
    logic zero;
    int   edge_n;
    int   vectors;
    int   miscompares;

    logic [1:0]  a_rst, c_rst, d_rst;
    logic [3:0]  b_rst;
    logic        a_all, b_all, c_all, d_all;
    logic        a_hit, b_hit, c_hit, d_hit;
    logic [31:0] a_cc, c_cc, d_cc;
    logic [3:0]  b_cc;

    mcpu_reset_seq #(.RUN_LIMIT(10)) u_a (
        .clkrst_core_clk(clk), .clkrst_core_rst_n(rst_a_n), .sw_rst_req(zero),
        .rst_out_n(a_rst), .all_released(a_all), .cycle_count(a_cc), .run_limit_hit(a_hit));

    mcpu_reset_seq #(.NUM_CHANNELS(4), .STAGGER(3), .CYC_WIDTH(4), .RUN_LIMIT(0)) u_b (
        .clkrst_core_clk(clk), .clkrst_core_rst_n(rst_a_n), .sw_rst_req(zero),
        .rst_out_n(b_rst), .all_released(b_all), .cycle_count(b_cc), .run_limit_hit(b_hit));

    mcpu_reset_seq u_c (
        .clkrst_core_clk(clk), .clkrst_core_rst_n(rst_a_n), .sw_rst_req(sw_c),
        .rst_out_n(c_rst), .all_released(c_all), .cycle_count(c_cc), .run_limit_hit(c_hit));

    mcpu_reset_seq u_d (
        .clkrst_core_clk(clk), .clkrst_core_rst_n(rst_d_n), .sw_rst_req(zero),
        .rst_out_n(d_rst), .all_released(d_all), .cycle_count(d_cc), .run_limit_hit(d_hit));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s @edge %0d: observed=%0h expected=%0h", tag, edge_n, obs, exp);
        end
    endtask

    // Advance to just after edge n so outputs are sampled away from the edge.
    task automatic step_to(input int n);
        while (edge_n < n) begin
            @(posedge clk);
            edge_n++;
        end
        #1;
    endtask

    initial begin
        edge_n      = 0;
        vectors     = 0;
        miscompares = 0;
        zero        = 1'b0;
        sw_c        = 1'b0;
        rst_a_n     = 1'b1;
        rst_d_n     = 1'b1;
        #1;
        rst_a_n = 1'b0;
        rst_d_n = 1'b0;
        #1;
        check("rst_a_rst", 32'(a_rst), 32'h0);
        check("rst_a_all", 32'(a_all), 32'h0);
        check("rst_a_cc",  a_cc,       32'h0);
        check("rst_a_hit", 32'(a_hit), 32'h0);
        check("rst_b_rst", 32'(b_rst), 32'h0);
        check("rst_d_rst", 32'(d_rst), 32'h0);
        #1;
        rst_a_n = 1'b1;
        rst_d_n = 1'b1;

        step_to(5);
        check("a_rst_e5", 32'(a_rst), 32'h0);
        step_to(6);
        check("a_rst_e6", 32'(a_rst), 32'h1);
        check("b_rst_e6", 32'(b_rst), 32'h1);
        check("c_rst_e6", 32'(c_rst), 32'h1);
        check("d_rst_e6", 32'(d_rst), 32'h1);
        step_to(7);
        check("a_all_e7", 32'(a_all), 32'h0);
        rst_d_n = 1'b0;
        #1;
        check("d_rst_async", 32'(d_rst), 32'h0);
        check("d_all_async", 32'(d_all), 32'h0);
        check("d_cc_async",  d_cc,       32'h0);

        step_to(8);
        check("a_rst_e8", 32'(a_rst), 32'h3);
        check("a_all_e8", 32'(a_all), 32'h1);
        check("a_cc_e8",  a_cc,       32'h0);
        check("c_rst_e8", 32'(c_rst), 32'h3);
        check("d_rst_e8", 32'(d_rst), 32'h0);
        step_to(9);
        check("b_rst_e9", 32'(b_rst), 32'h3);
        rst_d_n = 1'b1;
        step_to(12);
        check("b_rst_e12", 32'(b_rst), 32'h7);
        step_to(13);
        check("a_cc_e13", a_cc, 32'd5);
        step_to(14);
        check("b_all_e14", 32'(b_all), 32'h0);
        check("d_rst_e14", 32'(d_rst), 32'h0);
        step_to(15);
        check("b_rst_e15", 32'(b_rst), 32'hF);
        check("b_all_e15", 32'(b_all), 32'h1);
        check("b_cc_e15",  32'(b_cc),  32'h0);
        check("d_rst_e15", 32'(d_rst), 32'h1);
        step_to(17);
        check("a_cc_e17",  a_cc,       32'd9);
        check("a_hit_e17", 32'(a_hit), 32'h0);
        check("d_rst_e17", 32'(d_rst), 32'h3);
        check("d_all_e17", 32'(d_all), 32'h1);
        step_to(18);
        check("a_hit_e18", 32'(a_hit), 32'h1);
        check("a_rst_e18", 32'(a_rst), 32'h0);
        check("a_cc_e18",  a_cc,       32'd10);
        check("a_all_e18", 32'(a_all), 32'h0);

        step_to(19);
        check("c_cc_e19", c_cc, 32'd11);
        sw_c = 1'b1;
        step_to(20);
        sw_c = 1'b0;
        check("c_rst_e20", 32'(c_rst), 32'h0);
        check("c_cc_e20",  c_cc,       32'h0);
        check("c_all_e20", 32'(c_all), 32'h0);
        step_to(23);
        check("c_rst_e23", 32'(c_rst), 32'h0);
        step_to(24);
        check("c_rst_e24", 32'(c_rst), 32'h1);
        step_to(26);
        check("c_rst_e26", 32'(c_rst), 32'h3);
        check("c_all_e26", 32'(c_all), 32'h1);
        check("c_cc_e26",  c_cc,       32'h0);

        step_to(29);
        check("b_cc_e29", 32'(b_cc), 32'd14);
        step_to(30);
        check("b_cc_e30", 32'(b_cc), 32'd15);
        step_to(31);
        check("b_cc_e31", 32'(b_cc), 32'd15);
        step_to(40);
        check("a_hit_e40", 32'(a_hit), 32'h1);
        check("a_cc_e40",  a_cc,       32'd10);
        check("a_rst_e40", 32'(a_rst), 32'h0);
        check("b_cc_e40",  32'(b_cc),  32'd15);
        check("b_hit_e40", 32'(b_hit), 32'h0);
        check("c_cc_e40",  c_cc,       32'd14);
        check("c_hit_e40", 32'(c_hit), 32'h0);
        check("d_cc_e40",  d_cc,       32'd23);
        check("d_hit_e40", 32'(d_hit), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
